// File: rtl/cache_pkg.sv
// Shared types and encodings for the cache-side load/store unit.
// Holds the FSM state type, request size encoding, cache control constants and helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } req_size_t;

    localparam logic [4:0] LOAD_WORD  = 5'b00100;
    localparam logic [2:0] STORE_BYTE = 3'b001;
    localparam logic [2:0] STORE_HALF = 3'b010;
    localparam logic [2:0] STORE_WORD = 3'b100;

    // Size 3 has no legal alignment, so it is folded into the misaligned case.
    function automatic logic misaligned(input req_size_t size, input logic [1:0] lo);
        logic bad;
        unique case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [2:0] store_onehot(input req_size_t size);
        logic [2:0] sc;
        unique case (size)
            SZ_BYTE: sc = STORE_BYTE;
            SZ_HALF: sc = STORE_HALF;
            default: sc = STORE_WORD;
        endcase
        return sc;
    endfunction

endpackage

// File: rtl/cache_lsu_if.sv
// Pipeline request/response port plus CPU-side cache port of the load/store unit.
// The slave modport is the LSU view; master is the pipeline/cache environment view.
interface cache_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] din;
    logic [4:0]  loadcntrl;
    logic [2:0]  storecntrl;
    logic [31:0] dout;
    logic        cache_rdy;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  dout, cache_rdy,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ren, wen, addr, din, loadcntrl, storecntrl
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output dout, cache_rdy,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ren, wen, addr, din, loadcntrl, storecntrl
    );
endinterface

// File: rtl/cache_lsu_load_align.sv
// Combinational load lane select and sign/zero extension of a cache read word.
// Kept standalone so an uncached load path can share it.
module load_align
    import cache_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  off,
    input  req_size_t   size,
    input  logic        uns,
    output logic [31:0] result
);
    logic [7:0]  lanes [4];
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = data[8*gi +: 8];
        end
    endgenerate

    assign lane_b = lanes[off];
    assign lane_h = off[1] ? data[31:16] : data[15:0];

    always_comb begin
        unique case (size)
            SZ_BYTE: result = {{24{lane_b[7] & ~uns}}, lane_b};
            SZ_HALF: result = {{16{lane_h[15] & ~uns}}, lane_h};
            default: result = data;
        endcase
    end
endmodule

// File: rtl/cache_lsu.sv
// Single-outstanding load/store requester for the CPU-side cache port.
// Registered strobes, alignment check, timeout abandon and saturating stall counter.
module cache_lsu
    import cache_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    cache_lsu_if.slave       bus,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    lsu_state_t       state_reg, state_next;
    req_size_t        size_in, size_reg;
    logic             we_reg, uns_reg, err_reg;
    logic [1:0]       off_reg;
    logic [31:0]      dout_reg, aligned;
    logic [TMO_W-1:0] tmo_reg;
    logic [CNT_W-1:0] stall_reg;
    logic             ren_reg, ren_next, wen_reg, wen_next;
    logic [31:0]      addr_reg, addr_next, din_reg, din_next;
    logic [4:0]       lc_reg, lc_next;
    logic [2:0]       sc_reg, sc_next;
    logic             accept, bad, tmo_hit, busy, rdy_done;

    assign size_in  = req_size_t'(bus.req_size);
    assign accept   = (state_reg == S_IDLE) && bus.req_valid && bus.cache_rdy;
    assign bad      = misaligned(size_in, bus.req_addr[1:0]);
    assign tmo_hit  = (tmo_reg == TMO_W'(TIMEOUT - 1));
    assign busy     = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
    assign rdy_done = (state_reg == S_WAIT) && bus.cache_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // A returning cache_rdy in WAIT wins over a coincident timeout.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (accept) state_next = bad ? S_RESP : S_ISSUE;
            S_ISSUE: begin
                if (!bus.cache_rdy)  state_next = S_WAIT;
                else if (tmo_hit)    state_next = S_RESP;
            end
            S_WAIT:  if (bus.cache_rdy || tmo_hit) state_next = S_RESP;
            default: state_next = S_IDLE;
        endcase
    end

    // Cache-side outputs are computed here and registered, so req_* never reaches them combinationally.
    always_comb begin
        ren_next  = ren_reg;
        wen_next  = wen_reg;
        addr_next = addr_reg;
        din_next  = din_reg;
        lc_next   = lc_reg;
        sc_next   = sc_reg;
        if (accept && !bad) begin
            ren_next  = !bus.req_we;
            wen_next  = bus.req_we;
            addr_next = bus.req_we ? bus.req_addr : {bus.req_addr[31:2], 2'b00};
            din_next  = bus.req_we ? bus.req_wdata : 32'd0;
            lc_next   = bus.req_we ? 5'd0 : LOAD_WORD;
            sc_next   = bus.req_we ? store_onehot(size_in) : 3'd0;
        end else if ((state_reg == S_ISSUE) && (state_next != S_ISSUE)) begin
            ren_next = 1'b0;
            wen_next = 1'b0;
            lc_next  = 5'd0;
            sc_next  = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_reg   <= 1'b0;
            wen_reg   <= 1'b0;
            addr_reg  <= '0;
            din_reg   <= '0;
            lc_reg    <= '0;
            sc_reg    <= '0;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            err_reg   <= 1'b0;
            size_reg  <= SZ_BYTE;
            off_reg   <= '0;
            dout_reg  <= '0;
            tmo_reg   <= '0;
            stall_reg <= '0;
        end else begin
            ren_reg  <= ren_next;
            wen_reg  <= wen_next;
            addr_reg <= addr_next;
            din_reg  <= din_next;
            lc_reg   <= lc_next;
            sc_reg   <= sc_next;
            if (accept) begin
                we_reg   <= bus.req_we;
                uns_reg  <= bus.req_unsigned;
                size_reg <= size_in;
                off_reg  <= bus.req_addr[1:0];
                err_reg  <= bad;
                dout_reg <= '0;
                tmo_reg  <= '0;
            end else if (busy) begin
                tmo_reg <= tmo_reg + 1'b1;
            end
            if (rdy_done)
                dout_reg <= bus.dout;
            else if (busy && (state_next == S_RESP))
                err_reg <= 1'b1;
            if (busy && (stall_reg != {CNT_W{1'b1}}))
                stall_reg <= stall_reg + 1'b1;
        end
    end

    load_align u_align (
        .data   (dout_reg),
        .off    (off_reg),
        .size   (size_reg),
        .uns    (uns_reg),
        .result (aligned)
    );

    assign bus.req_ready  = (state_reg == S_IDLE) && bus.cache_rdy;
    assign bus.resp_valid = (state_reg == S_RESP);
    assign bus.resp_err   = (state_reg == S_RESP) && err_reg;
    assign bus.resp_rdata = ((state_reg == S_RESP) && !err_reg && !we_reg) ? aligned : 32'd0;
    assign bus.ren        = ren_reg;
    assign bus.wen        = wen_reg;
    assign bus.addr       = addr_reg;
    assign bus.din        = din_reg;
    assign bus.loadcntrl  = lc_reg;
    assign bus.storecntrl = sc_reg;
    assign stall_cnt      = stall_reg;
endmodule

// File: tb/tb_cache_lsu.sv
// Bench for cache_lsu: behavioural cache with programmable penalty, table vectors,
// randomized traffic against an arithmetic reference memory, and timeout/reset corners.
module tb_cache_lsu;
    import cache_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_cnt;
    cache_lsu_if bus ();

    always #5 clk = ~clk;

    cache_lsu #(.TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] cold_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hA5C3_9E17;
    endfunction

    // ---------------- behavioural cache: mode 0 normal, 1 never re-raises rdy, 2 ignores strobes
    logic [31:0] cmem [0:4095];
    logic        mem_inited = 1'b0;
    int          mdl_mode;
    int          pen;
    logic        mdl_clr;
    logic        mbusy;
    int          mcnt;
    logic [31:0] maddr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] sc,
                                          input logic [1:0] off, input logic [31:0] d);
        logic [31:0] w;
        w = old;
        case (sc)
            3'b001:  w[8*off +: 8] = d[7:0];
            3'b010:  w[16*off[1] +: 16] = d[15:0];
            3'b100:  w = d;
            default: w = old;
        endcase
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || mdl_clr) begin
            bus.cache_rdy <= 1'b1;
            bus.dout      <= '0;
            mbusy         <= 1'b0;
            mcnt          <= 0;
            if (!mem_inited) begin
                for (int i = 0; i < 4096; i++) cmem[i] <= cold_word(32'(i) << 2);
                mem_inited <= 1'b1;
            end
        end else if (mbusy) begin
            if (mdl_mode == 0) begin
                if (mcnt == 1) begin
                    bus.cache_rdy <= 1'b1;
                    mbusy         <= 1'b0;
                    bus.dout      <= cmem[maddr[13:2]];
                end
                mcnt <= mcnt - 1;
            end
        end else if (bus.cache_rdy && (bus.ren || bus.wen) && mdl_mode != 2) begin
            bus.cache_rdy <= 1'b0;
            mbusy         <= 1'b1;
            mcnt          <= pen;
            maddr         <= bus.addr;
            if (bus.wen)
                cmem[bus.addr[13:2]] <= merge(cmem[bus.addr[13:2]], bus.storecntrl, bus.addr[1:0], bus.din);
        end
    end

    // ---------------- reference model: memory as plain words, rules by arithmetic
    logic [31:0] ref_mem [0:4095];

    function automatic logic ref_bad(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        logic [31:0] w, v;
        w = ref_mem[a[13:2]];
        if (sz == 2'd0) begin
            v = (w >> (8 * a[1:0])) & 32'hff;
            if (!uns && v[7]) v = v | 32'hffff_ff00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * a[1])) & 32'hffff;
            if (!uns && v[15]) v = v | 32'hffff_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w, mask;
        w = ref_mem[a[13:2]];
        if (sz == 2'd0)      mask = 32'hff << (8 * a[1:0]);
        else if (sz == 2'd1) mask = 32'hffff << (16 * a[1]);
        else                 mask = 32'hffff_ffff;
        ref_mem[a[13:2]] = (w & ~mask) | ((wd << (8 * a[1:0])) & mask);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
        end
    endtask

    // ---------------- one request/response transaction, observations left in these variables
    logic        got_err, pulse_ok, snap_ren, snap_wen;
    logic [31:0] got_rdata, got_stall, snap_addr, snap_din;
    logic [4:0]  snap_lc;
    logic [2:0]  snap_sc;
    int          got_lat, got_strb, got_var;

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        int          guard;
        logic [31:0] s0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!bus.req_ready) begin
            chk("accept_bound", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        s0 = stall_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        got_lat = 0; got_strb = 0; got_var = 0;
        {snap_ren, snap_wen, snap_addr, snap_din, snap_lc, snap_sc} = '0;
        while (got_lat < 200) begin
            @(negedge clk);
            got_lat++;
            if (bus.ren || bus.wen) begin
                if (got_strb == 0) begin
                    snap_ren = bus.ren; snap_wen = bus.wen; snap_addr = bus.addr;
                    snap_din = bus.din; snap_lc = bus.loadcntrl; snap_sc = bus.storecntrl;
                end else if ({bus.ren, bus.wen, bus.addr, bus.din, bus.loadcntrl, bus.storecntrl} !=
                             {snap_ren, snap_wen, snap_addr, snap_din, snap_lc, snap_sc}) begin
                    got_var++;
                end
                got_strb++;
            end
            if (bus.resp_valid) break;
        end
        if (!bus.resp_valid) chk("resp_bound", 32'(bus.resp_valid), 32'd1);
        got_err   = bus.resp_err;
        got_rdata = bus.resp_rdata;
        got_stall = stall_cnt - s0;
        @(negedge clk);
        pulse_ok = !bus.resp_valid;
        $display("xact we=%0d sz=%0d uns=%0d addr=%08h wd=%08h -> err=%0d rdata=%08h lat=%0d stall=%0d",
                 we, sz, uns, a, wd, got_err, got_rdata, got_lat, got_stall);
    endtask

    // Runs one normal-mode transaction and checks it fully against the reference model.
    task automatic run_chk(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input int p);
        logic        eb;
        logic [31:0] er;
        pen = p;
        eb = ref_bad(sz, a);
        er = (eb || we) ? 32'd0 : ref_load(sz, uns, a);
        xact(we, sz, uns, a, wd);
        chk("err", 32'(got_err), 32'(eb));
        chk("rdata", got_rdata, er);
        chk("latency", got_lat, eb ? 32'd1 : 32'(3 + p));
        chk("stall_delta", got_stall, eb ? 32'd0 : 32'(2 + p));
        chk("strobe_cycles", got_strb, eb ? 32'd0 : 32'd2);
        chk("resp_pulse", 32'(pulse_ok), 32'd1);
        if (!eb) begin
            chk("strobe_held", got_var, 32'd0);
            chk("strobe_kind", {snap_ren, snap_wen}, we ? 32'd1 : 32'd2);
            chk("cache_addr", snap_addr, we ? a : (a & 32'hffff_fffc));
            chk("loadcntrl", 32'(snap_lc), we ? 32'd0 : 32'(LOAD_WORD));
            chk("storecntrl", 32'(snap_sc), we ? (32'd1 << sz) : 32'd0);
            if (we) begin
                chk("din", snap_din, wd);
                ref_store(sz, a, wd);
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] exp_caddr;
    } vec_t;

    vec_t tbl [13];

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ren"}, 32'(bus.ren), 32'd0);
        chk({tag, "_wen"}, 32'(bus.wen), 32'd0);
        chk({tag, "_addr"}, bus.addr, 32'd0);
        chk({tag, "_din"}, bus.din, 32'd0);
        chk({tag, "_ctrl"}, {bus.loadcntrl, bus.storecntrl}, 32'd0);
        chk({tag, "_resp"}, {bus.resp_valid, bus.resp_err}, 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_stall"}, stall_cnt, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'hdeadbeef, 1'b0, 32'h0,        32'h1000};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        1'b0, 32'hdeadbeef, 32'h1000};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0,        1'b0, 32'hffffffde, 32'h1000};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h1003, 32'h0,        1'b0, 32'h000000de, 32'h1000};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h1002, 32'h0,        1'b0, 32'hffffdead, 32'h1000};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h1000, 32'h0,        1'b0, 32'h0000beef, 32'h1000};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h1002, 32'h0,        1'b1, 32'h0,        32'h0};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h1001, 32'h0,        1'b1, 32'h0,        32'h0};
        tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h1000, 32'h0,        1'b1, 32'h0,        32'h0};
        tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h1001, 32'h12345677, 1'b0, 32'h0,        32'h1001};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        1'b0, 32'hdead77ef, 32'h1000};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h1002, 32'haaaa5555, 1'b0, 32'h0,        32'h1002};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 32'h1001, 32'h0,        1'b0, 32'h00000077, 32'h1000};

        for (int i = 0; i < 4096; i++) ref_mem[i] = cold_word(32'(i) << 2);
        mdl_mode = 0; pen = 1; mdl_clr = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Cold word load with a 5-cycle miss penalty.
        run_chk(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 5);
        chk("cold_lw_data", got_rdata, 32'hA5C39E17);
        chk("cold_lw_stall", stall_cnt, 32'd7);

        for (int i = 0; i < 13; i++) begin
            pen = (i % 3) + 1;
            xact(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd);
            chk($sformatf("tbl%0d_err", i), 32'(got_err), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_rdata", i), got_rdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_lat", i), got_lat, tbl[i].exp_err ? 32'd1 : 32'(3 + pen));
            chk($sformatf("tbl%0d_stall", i), got_stall, tbl[i].exp_err ? 32'd0 : 32'(2 + pen));
            chk($sformatf("tbl%0d_strobes", i), got_strb, tbl[i].exp_err ? 32'd0 : 32'd2);
            if (!tbl[i].exp_err) chk($sformatf("tbl%0d_caddr", i), snap_addr, tbl[i].exp_caddr);
            if (tbl[i].we && !tbl[i].exp_err) ref_store(tbl[i].sz, tbl[i].a, tbl[i].wd);
        end

        for (int i = 0; i < 40; i++)
            run_chk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    32'h2000 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(1, 4));

        // Cache drops rdy and never returns it: abandoned in WAIT.
        mdl_mode = 1;
        xact(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0);
        chk("tmo_wait_err", 32'(got_err), 32'd1);
        chk("tmo_wait_rdata", got_rdata, 32'd0);
        chk("tmo_wait_lat", got_lat, 32'(TMO + 1));
        chk("tmo_wait_stall", got_stall, 32'(TMO));
        chk("tmo_wait_pulse", 32'(pulse_ok), 32'd1);

        // cache_rdy still low in IDLE: the request must wait unaccepted.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy_ready", 32'(bus.req_ready), 32'd0);
            chk("idle_busy_ren", 32'(bus.ren), 32'd0);
        end
        mdl_clr = 1'b1;
        @(posedge clk); #1;
        mdl_clr = 1'b0; mdl_mode = 0;
        run_chk(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 2);

        // Cache never drops rdy: abandoned from ISSUE with the strobe held throughout.
        mdl_mode = 2;
        xact(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0);
        chk("tmo_issue_err", 32'(got_err), 32'd1);
        chk("tmo_issue_rdata", got_rdata, 32'd0);
        chk("tmo_issue_lat", got_lat, 32'(TMO + 1));
        chk("tmo_issue_strobes", got_strb, 32'(TMO));
        chk("tmo_issue_held", got_var, 32'd0);
        mdl_mode = 0;
        run_chk(1'b1, 2'd2, 1'b0, 32'h2008, 32'h0bad_cafe, 1);

        // Asynchronous reset while waiting on the cache.
        mdl_mode = 1;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h2004;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_strobe_low", 32'(bus.ren), 32'd0);
        chk("wait_addr_held", bus.addr, 32'h2004);
        #2 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0; mdl_mode = 0;
        run_chk(1'b0, 2'd2, 1'b0, 32'h2008, 32'h0, 3);
        chk("post_rst_stall", stall_cnt, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time bound exceeded");
    end
endmodule

// File: doc/cache_lsu.md
# cache_lsu

Load/store requester driving the CPU-side port of `cache`. Accepts one memory-stage request at a time from the pipeline and runs the `ren`/`wen` + `cache_rdy` handshake. Returns load data byte/half-extracted and sign/zero-extended, and rejects misaligned accesses without touching the cache. Also counts stall cycles for miss-penalty measurement.

## Interface
- `TIMEOUT`, 4096: cycles in WAIT before the request is abandoned with `resp_err`.
- `CNT_W`, 32: width of `stall_cnt`.
---
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  pipeline request strobe.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- `req_unsigned`  in  1  zero-extend a load when set.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, low-order bits.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  32  extended load data (0 for stores).
- `resp_err`  out  1  misaligned or timeout.
- `ren`, `wen`  out  1  cache access strobes.
- `addr`  out  32  cache address.
- `din`  out  32  cache write data.
- `loadcntrl`  out  5  always 5'b00100 (word) during a load, else 0.
- `storecntrl`  out  3  one-hot: bit0 byte, bit1 half, bit2 word. 0 when idle.
- `dout`  in  32  cache read data.
- `cache_rdy`  in  1  cache idle/ready.
- `stall_cnt`  out  CNT_W  cycles spent in ISSUE+WAIT since reset; saturates.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE.** `req_ready = cache_rdy`. On accept:
  - Misaligned request (half with `addr[0]`, word with `addr[1:0] != 0`, or size 3): go to RESP with `resp_err = 1`. No cache strobe.
  - Otherwise latch the request and go to ISSUE.
- **ISSUE.** Hold the strobe and all cache outputs constant.
  - Loads: `ren = 1`, `addr = {req_addr[31:2], 2'b00}`, `loadcntrl = 5'b00100`.
  - Stores: `wen = 1`, `addr = req_addr`, `din = req_wdata`, `storecntrl` one-hot from size.
  - Leave for WAIT on the first cycle `cache_rdy == 0`. Strobes and ctrl drop to 0 in that same transition.
- **WAIT.**
  - When `cache_rdy == 1`: capture `dout` and go to RESP.
  - When the timeout counter reaches `TIMEOUT - 1`: go to RESP with `resp_err = 1`.
- **RESP.**
  - `resp_valid = 1` for exactly one cycle, then IDLE.
  - Loads: `resp_rdata` = lane `dout[8*addr[1:0] +: 8]` for byte, or `dout[16*addr[1] +: 16]` for half, sign-extended unless `req_unsigned`.
  - Timeout error: `resp_rdata = 0`.
- Only one outstanding request; no new request is accepted in ISSUE/WAIT/RESP (`req_ready = 0`).
- `stall_cnt` increments every cycle in ISSUE or WAIT and holds at all-ones.

## Timing
- Reset values: all outputs 0 and state IDLE, including `ren`, `wen`, `addr`, `din`, ctrl, `resp_*` and `stall_cnt`. Reset mid-transaction drops strobes immediately (async).
- Accept at edge N.
  - Strobe is high from N+1, registered; no combinational path from `req_*` to cache outputs.
  - Earliest response with a hit that drops `cache_rdy` for one cycle: strobe at N+1, `cache_rdy` low seen at N+2, high seen at N+3, `resp_valid` during N+4.
- Misaligned: `resp_valid` during the cycle after accept.
- If `cache_rdy` never falls in ISSUE, the timeout counter also runs there and the same timeout rule applies.
- `cache_rdy` low while in IDLE: `req_ready = 0`; the request waits.

## Structure
- Package `cache_pkg`:
  - typedef `lsu_state_t` for the four states.
  - typedef for `req_size` encoding.
  - constants `LOAD_WORD = 5'b00100`, `STORE_BYTE/HALF/WORD = 3'b001/010/100`.
- One sub-module `load_align`: a combinational lane select plus extension on (`dout`, `addr[1:0]`, size, unsigned). It is reused by any future uncached path.

## Test plan
- Reset, then LW at 0x0 on a cold cache → `ren` held until `cache_rdy` falls, with `loadcntrl = 00100`. `resp_rdata` equals the memory word; `stall_cnt` equals the miss penalty in cycles.
- SW `0xdeadbeef` to 0x1000, then LW 0x1000 → store has `storecntrl = 100`, `din = 0xdeadbeef`; the load returns `0xdeadbeef`.
- LB 0x1003 signed and LBU 0x1003 → `0xffffffde` and `0x000000de`. LH 0x1002 signed → `0xffffdead`. Cache `addr = 0x1000` in all cases.
- LW 0x1002 and LH 0x1001 → `resp_err = 1` one cycle after accept, `ren`/`wen` never asserted, `stall_cnt` unchanged.
- Cache model never raises `cache_rdy` after the strobe, with `TIMEOUT = 16` → `resp_err` with `resp_rdata = 0` and return to IDLE.
- Assert `rst` during WAIT → all outputs 0 within the same cycle; the next request completes normally.
